// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a 5-stage RV32I core.
// Drives per-stage stall/flush, EX operand forwarding selects, a post-reset flush
// sequence, multi-cycle EX occupancy tracking, and saturating perf counters.
// Ports:
//   clk, CpuRst_n                      clock, async active-low reset
//   ICacheMiss, DCacheMiss             miss levels, held until served
//   BranchE, JalrE, JalD               redirect sources
//   MulDivStartE                       EX holds a multi-cycle op
//   Rs1D, Rs2D, Rs1E, Rs2E, RdE/M/W    register numbers
//   RegReadE, MemToRegE, RegWriteM/W   operand use, load, writeback enables
//   CntClr                             sync clear of perf counters
//   StallF..W, FlushF..W               segment register controls
//   Forward1E, Forward2E               00 regfile, 10 MEM, 01 WB
//   MdBusy, StallCnt, RedirCnt         status and perf counters
module hazard_ctrl #(
  parameter int RST_FLUSH_CYC = 2,
  parameter int MD_LAT        = 4,
  parameter int CNT_W         = 16,
  parameter int REG_AW        = 5
) (
  input  logic              clk,
  input  logic              CpuRst_n,
  input  logic              ICacheMiss,
  input  logic              DCacheMiss,
  input  logic              BranchE,
  input  logic              JalrE,
  input  logic              JalD,
  input  logic              MulDivStartE,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic [1:0]        RegReadE,
  input  logic              MemToRegE,
  input  logic [2:0]        RegWriteM,
  input  logic [2:0]        RegWriteW,
  input  logic              CntClr,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              StallW,
  output logic              FlushF,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              FlushW,
  output logic [1:0]        Forward1E,
  output logic [1:0]        Forward2E,
  output logic              MdBusy,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  RedirCnt
);
  localparam int RW = $clog2(RST_FLUSH_CYC + 1);
  localparam int MW = MD_LAT > 1 ? $clog2(MD_LAT) : 1;
  localparam logic [RW-1:0] RST_LD = RW'(RST_FLUSH_CYC);
  localparam logic [MW-1:0] MD_TOP = MW'(MD_LAT - 1);
  logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [MW-1:0]    md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, redir_cnt_q, redir_cnt_d;
  logic             rst_phase, md_busy, load_use, redir, redir_fire;
  logic             hit_m1, hit_w1, hit_m2, hit_w2;
  logic [4:0]       st, fl;
  assign rst_phase  = !CpuRst_n || rst_cnt_q != '0;
  assign md_busy    = MulDivStartE && md_cnt_q != MD_TOP;
  assign load_use   = MemToRegE && RdE != '0 && (RdE == Rs1D || RdE == Rs2D);
  assign redir      = BranchE || JalrE;
  assign redir_fire = !rst_phase && !DCacheMiss && !md_busy && redir;
  assign MdBusy     = md_busy && !rst_phase;
  // First matching rule wins; reset phase flushes everything.
  always_comb begin
    st = '0;
    fl = '0;
    if (rst_phase) fl = '1;
    else if (DCacheMiss) begin st = 5'b11110; fl = 5'b00001; end
    else if (md_busy) begin st = 5'b11100; fl = 5'b00010; end
    else if (redir) fl = 5'b01100;
    else if (load_use) begin st = 5'b11000; fl = 5'b00100; end
    else if (JalD) fl = 5'b01000;
    else if (ICacheMiss) begin st = 5'b10000; fl = 5'b01000; end
  end
  assign {StallF, StallD, StallE, StallM, StallW} = st;
  assign {FlushF, FlushD, FlushE, FlushM, FlushW} = fl;
  assign hit_m1 = RegReadE[1] && RegWriteM != '0 && RdM != '0 && RdM == Rs1E;
  assign hit_w1 = RegReadE[1] && RegWriteW != '0 && RdW != '0 && RdW == Rs1E;
  assign hit_m2 = RegReadE[0] && RegWriteM != '0 && RdM != '0 && RdM == Rs2E;
  assign hit_w2 = RegReadE[0] && RegWriteW != '0 && RdW != '0 && RdW == Rs2E;
  assign Forward1E = hit_m1 ? 2'b10 : hit_w1 ? 2'b01 : 2'b00;
  assign Forward2E = hit_m2 ? 2'b10 : hit_w2 ? 2'b01 : 2'b00;
  // MdCnt freezes under a data-cache miss so the op keeps its full EX residency.
  always_comb begin
    rst_cnt_d   = rst_cnt_q == '0 ? '0 : rst_cnt_q - 1'b1;
    md_cnt_d    = !MulDivStartE ? '0 : DCacheMiss ? md_cnt_q : md_cnt_q == MD_TOP ? '0 : md_cnt_q + 1'b1;
    stall_cnt_d = CntClr ? '0 : (StallF && !rst_phase && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    redir_cnt_d = CntClr ? '0 : (redir_fire && redir_cnt_q != '1) ? redir_cnt_q + 1'b1 : redir_cnt_q;
  end
  always_ff @(posedge clk or negedge CpuRst_n) begin
    if (!CpuRst_n) begin
      rst_cnt_q   <= RST_LD;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      rst_cnt_q   <= rst_cnt_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end
  assign StallCnt = stall_cnt_q;
  assign RedirCnt = redir_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl (CNT_W=4 to reach saturation quickly).
module tb_hazard_ctrl;
  logic clk = 0;
  logic CpuRst_n, ICacheMiss, DCacheMiss, BranchE, JalrE, JalD, MulDivStartE, MemToRegE, CntClr;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] RegReadE;
  logic [2:0] RegWriteM, RegWriteW;
  logic StallF, StallD, StallE, StallM, StallW, FlushF, FlushD, FlushE, FlushM, FlushW, MdBusy;
  logic [1:0] Forward1E, Forward2E;
  logic [3:0] StallCnt, RedirCnt;
  typedef struct {
    string      name;
    logic [14:0] exp;
    logic       chk;
    logic [3:0] sc;
    logic [3:0] rc;
  } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  hazard_ctrl #(.RST_FLUSH_CYC(2), .MD_LAT(4), .CNT_W(4), .REG_AW(5)) dut (
    .clk(clk), .CpuRst_n(CpuRst_n), .ICacheMiss(ICacheMiss), .DCacheMiss(DCacheMiss),
    .BranchE(BranchE), .JalrE(JalrE), .JalD(JalD), .MulDivStartE(MulDivStartE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegReadE(RegReadE), .MemToRegE(MemToRegE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .CntClr(CntClr), .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .StallW(StallW), .FlushF(FlushF), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .FlushW(FlushW), .Forward1E(Forward1E), .Forward2E(Forward2E), .MdBusy(MdBusy),
    .StallCnt(StallCnt), .RedirCnt(RedirCnt)
  );
  // Monitor: outputs are combinational, so every checked cycle presents a response at negedge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [14:0] act;
      e = q.pop_front();
      act = {StallF, StallD, StallE, StallM, StallW, FlushF, FlushD, FlushE, FlushM, FlushW,
             Forward1E, Forward2E, MdBusy};
      tests++;
      if (act !== e.exp) begin
        fails++;
        $display("FAIL %s: ctrl got %b expected %b (stall|flush|f1|f2|md)", e.name, act, e.exp);
      end
      if (e.chk) begin
        tests++;
        if (StallCnt !== e.sc || RedirCnt !== e.rc) begin
          fails++;
          $display("FAIL %s_cnt: stall/redir got %0d/%0d expected %0d/%0d", e.name, StallCnt, RedirCnt, e.sc, e.rc);
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input string n, input logic [4:0] st, input logic [4:0] fl, input logic [1:0] f1,
                      input logic [1:0] f2, input logic md, input logic c, input int sc, input int rc);
    exp_t e;
    e.name = n;
    e.exp = {st, fl, f1, f2, md};
    e.chk = c;
    e.sc = 4'(sc);
    e.rc = 4'(rc);
    q.push_back(e);
  endtask
  task automatic idle();
    {ICacheMiss, DCacheMiss, BranchE, JalrE, JalD, MulDivStartE, MemToRegE, CntClr} = '0;
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    RegReadE = '0;
    RegWriteM = '0;
    RegWriteW = '0;
  endtask
  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    CpuRst_n = 0;
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      push("reset", 5'b00000, 5'b11111, 2'b00, 2'b00, 1'b0, 1'b1, 0, 0);
    end
    step(); CpuRst_n = 1;
    push("rst_seq0", 5'b00000, 5'b11111, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0);
    step();
    push("rst_seq1", 5'b00000, 5'b11111, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0);
    step();
    push("rst_done", 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0, 1'b1, 0, 0);
    step(); MemToRegE = 1; RdE = 5; Rs1D = 5;
    push("load_use", 5'b11000, 5'b00100, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0);
    step(); idle(); Rs1E = 5; RegReadE = 2'b10; RdM = 5; RegWriteM = 3'd1;
    push("lu_fwd_mem", 5'b00000, 5'b00000, 2'b10, 2'b00, 1'b0, 1'b1, 1, 0);
    step(); RdM = 0; RegWriteM = 0; RdW = 5; RegWriteW = 3'd1;
    push("lu_fwd_wb", 5'b00000, 5'b00000, 2'b01, 2'b00, 1'b0, 1'b0, 1, 0);
    step(); idle(); MulDivStartE = 1;
    for (int i = 0; i < 3; i++) begin
      push("md_busy", 5'b11100, 5'b00010, 2'b00, 2'b00, 1'b1, 1'b0, 0, 0);
      step();
    end
    push("md_last", 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0, 1'b1, 4, 0);
    step(); MulDivStartE = 0;
    push("md_idle", 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0, 1'b0, 4, 0);
    step(); MulDivStartE = 1;
    push("mdd_c1", 5'b11100, 5'b00010, 2'b00, 2'b00, 1'b1, 1'b0, 0, 0);
    step(); DCacheMiss = 1;
    push("mdd_c2", 5'b11110, 5'b00001, 2'b00, 2'b00, 1'b1, 1'b0, 0, 0);
    step();
    push("mdd_c3", 5'b11110, 5'b00001, 2'b00, 2'b00, 1'b1, 1'b0, 0, 0);
    step(); DCacheMiss = 0;
    push("mdd_c4", 5'b11100, 5'b00010, 2'b00, 2'b00, 1'b1, 1'b0, 0, 0);
    step();
    push("mdd_c5", 5'b11100, 5'b00010, 2'b00, 2'b00, 1'b1, 1'b0, 0, 0);
    step();
    push("mdd_c6", 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0, 1'b1, 9, 0);
    step(); idle(); BranchE = 1; MemToRegE = 1; RdE = 5; Rs1D = 5; ICacheMiss = 1;
    push("prio_branch", 5'b00000, 5'b01100, 2'b00, 2'b00, 1'b0, 1'b0, 9, 0);
    step(); idle();
    push("prio_after", 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0, 1'b1, 9, 1);
    step(); JalD = 1; ICacheMiss = 1;
    push("jald_icache", 5'b00000, 5'b01000, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0);
    step(); JalD = 0;
    push("icache", 5'b10000, 5'b01000, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0);
    step(); ICacheMiss = 0; JalD = 1; MemToRegE = 1; RdE = 9; Rs2D = 9;
    push("lu_over_jald", 5'b11000, 5'b00100, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0);
    step(); idle(); DCacheMiss = 1; BranchE = 1;
    push("dmiss_over_br", 5'b11110, 5'b00001, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0);
    step(); idle();
    push("after_dmiss", 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0, 1'b1, 12, 1);
    step(); RdM = 7; RdW = 7; Rs2E = 7; RegReadE = 2'b01; RegWriteM = 3'd1; RegWriteW = 3'd4;
    push("fwd_mem_wins", 5'b00000, 5'b00000, 2'b00, 2'b10, 1'b0, 1'b0, 0, 0);
    step(); RdM = 0;
    push("fwd_wb", 5'b00000, 5'b00000, 2'b00, 2'b01, 1'b0, 1'b0, 0, 0);
    step(); RegReadE = 2'b00;
    push("fwd_unused", 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0);
    step(); RegReadE = 2'b11; Rs1E = 7; RdM = 7; RegWriteM = 3'd0;
    push("fwd_nowrite_m", 5'b00000, 5'b00000, 2'b01, 2'b01, 1'b0, 1'b0, 0, 0);
    step(); idle(); ICacheMiss = 1;
    for (int i = 0; i < 20; i++) begin
      push("sat_icache", 5'b10000, 5'b01000, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0);
      step();
    end
    ICacheMiss = 0;
    push("sat_value", 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0, 1'b1, 15, 1);
    step(); CntClr = 1; ICacheMiss = 1;
    push("clr_cycle", 5'b10000, 5'b01000, 2'b00, 2'b00, 1'b0, 1'b1, 15, 1);
    step(); idle();
    push("clr_done", 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0, 1'b1, 0, 0);
    step(); MulDivStartE = 1;
    push("pre_rst_md1", 5'b11100, 5'b00010, 2'b00, 2'b00, 1'b1, 1'b0, 0, 0);
    step();
    push("pre_rst_md2", 5'b11100, 5'b00010, 2'b00, 2'b00, 1'b1, 1'b1, 1, 0);
    step(); MulDivStartE = 0; CpuRst_n = 0;
    push("mid_reset", 5'b00000, 5'b11111, 2'b00, 2'b00, 1'b0, 1'b1, 0, 0);
    step(); CpuRst_n = 1;
    push("mid_rst_seq0", 5'b00000, 5'b11111, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0);
    step();
    push("mid_rst_seq1", 5'b00000, 5'b11111, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0);
    step(); JalrE = 1;
    push("post_rst_jalr", 5'b00000, 5'b01100, 2'b00, 2'b00, 1'b0, 1'b1, 0, 0);
    step(); idle();
    push("post_rst_cnt", 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0, 1'b1, 0, 1);
    step();
    step();
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage RV32I core: a superset of the basic hazard unit. It generates per-stage Stall/Flush and EX-stage forwarding selects. It also adds the following behaviour: a post-reset flush sequencer, a multi-cycle (mul/div) EX occupancy counter, cache-miss freezing and saturating stall/redirect performance counters. It sits beside the datapath and drives the five segment registers and the two EX operand muxes.

## Interface
- RST_FLUSH_CYC, 2: cycles all stages stay flushed after reset release (≥1).
- MD_LAT, 4: EX residency in cycles of a multi-cycle op (≥1; 1 = no stall).
- CNT_W, 16: width of performance counters.
- REG_AW, 5: register-address width.
- clk  in  1  core clock, rising edge.
- CpuRst_n  in  1  asynchronous active-low reset.
- ICacheMiss, DCacheMiss  in  1  level, held until the miss is served.
- BranchE, JalrE, JalD  in  1  taken branch / jalr in EX; jal in ID.
- MulDivStartE  in  1  EX holds a multi-cycle op; high for its whole EX residency.
- Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW  in  REG_AW  register numbers.
- RegReadE  in  2  [1] rs1 used, [0] rs2 used.
- MemToRegE  in  1  EX instruction is a load.
- RegWriteM, RegWriteW  in  3  nonzero = writes Rd.
- CntClr  in  1  synchronous clear of both counters.
- StallF..StallW, FlushF..FlushW  out  1 each  segment-register controls.
- Forward1E, Forward2E  out  2  00 regfile, 10 from MEM, 01 from WB.
- MdBusy  out  1  multi-cycle op is holding EX.
- StallCnt, RedirCnt  out  CNT_W  performance counters.

## Operation
- State: RstCnt (0..RST_FLUSH_CYC), MdCnt (0..MD_LAT-1), StallCnt, RedirCnt. Outputs are combinational from inputs and state.
- Priority, highest first. A lower rule applies only if no higher rule fired.
  1. Reset phase (CpuRst_n=0 or RstCnt≠0): all Flush=1, all Stall=0.
  2. DCacheMiss: StallF/D/E/M=1, FlushW=1. Redirects are ignored. MdCnt is frozen.
  3. MdBusy = MulDivStartE & (MdCnt≠MD_LAT-1): StallF/D/E=1, FlushM=1.
  4. BranchE|JalrE: FlushD=1, FlushE=1, StallF=0. This overrides load-use and ICacheMiss.
  5. Load-use (MemToRegE, RdE≠0, RdE==Rs1D or Rs2D): StallF=1, StallD=1, FlushE=1.
  6. JalD: FlushD=1, StallF=0. This overrides ICacheMiss.
  7. ICacheMiss: StallF=1, FlushD=1.
- Any control not asserted by the firing rule is 0.
- MdCnt:
  - 0 when MulDivStartE=0.
  - Otherwise, when not DCacheMiss, it increments, and MD_LAT-1 wraps to 0.
  - A multi-cycle op therefore holds EX for exactly MD_LAT cycles.
- RstCnt:
  - Loaded to RST_FLUSH_CYC while reset is asserted.
  - Decrements by 1 each cycle until 0.
- Forwarding, with x=1/2 and RegReadE bit 1/0:
  - Forward x = 10 if bit & RegWriteM≠0 & RdM≠0 & RdM==RsxE.
  - Else 01 under the same test on the W-stage signals.
  - Else 00.
  - MEM beats WB. Forwarding is independent of the priority rules.
- StallCnt: +1 on every cycle with StallF=1 outside the reset phase.
- RedirCnt: +1 on every cycle where rule 4 fires.
- Both counters saturate at all-ones. CntClr zeroes both, and CntClr wins over increment.

## Timing
- Reset values: all Flush=1, all Stall=0, Forward=00, MdBusy=0. Counters=0, MdCnt=0, RstCnt=RST_FLUSH_CYC.
- After CpuRst_n rises, Flush stays 1 for RST_FLUSH_CYC rising edges, then falls.
- Load-use costs exactly 1 bubble, and the dependent instruction then receives Forward=01.
- A branch or jalr redirect costs 2 flushed slots. JalD costs 1.
- A multi-cycle op stalls the front end for MD_LAT-1 cycles. MdBusy falls in its last EX cycle.
- Misses: stall/flush lasts while the level is high and releases the same cycle it drops.
- Reset asserted mid-operation: MdCnt and RstCnt reload immediately (async). Counters clear.

## Test plan
- Reset and sequencing:
  - Hold CpuRst_n=0 for 3 cycles, then release with RST_FLUSH_CYC=2.
  - Required: Flush*=1 for 2 more edges, then 0.
  - Required: StallCnt=0 and RedirCnt=0.
- Load-use:
  - MemToRegE=1, RdE=5, Rs1D=5.
  - Required: StallF=StallD=FlushE=1 for one cycle.
  - Next cycle, with RdM=5 and RegWriteM=1: Forward1E=10.
- Multi-cycle op:
  - MulDivStartE high with MD_LAT=4.
  - Required: MdBusy and StallF/D/E plus FlushM for 3 cycles, then released on the 4th.
  - Assert DCacheMiss during cycle 2 for 2 cycles. Required: busy stretches to 5 cycles total.
- Priority:
  - BranchE=1 with load-use and ICacheMiss simultaneously.
  - Required: FlushD=FlushE=1, StallF=0, RedirCnt +1.
- Forward precedence:
  - RdM=RdW=7=Rs2E, RegReadE=01, both writes enabled. Required: Forward2E=10.
  - With RdM=0. Required: Forward2E=01.
  - With RegReadE=00. Required: Forward2E=00.
- Counter saturation:
  - Set CNT_W=4 and hold ICacheMiss for 20 cycles. Required: StallCnt=15.
  - Pulse CntClr. Required: StallCnt=0 next cycle.
